// File: rtl/full_subtractor_pkg.sv
// Shared arithmetic constants for the full_subtractor slice.
package full_subtractor_pkg;

  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bo is the borrow out.
module fs_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow arrives from below.
  assign bo      = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {bout, diff} = a - b - bin, one cycle latency.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("full_subtractor: WIDTH out of range");
  end

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] d_vec;

  assign br[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .bin(br[i]),
      .d  (d_vec[i]),
      .bo (br[i+1])
    );
  end

  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;
  logic             valid_q;

  // Result registers only load on qualified cycles; otherwise they hold.
  always_comb begin
    diff_d = diff_q;
    bout_d = bout_q;
    if (in_valid) begin
      diff_d = d_vec;
      bout_d = br[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q  <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      valid_q <= in_valid;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: exhaustive 1-bit, directed 8-bit, random 16-bit against an integer model.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic [0:0]  a1, b1, d1;
  logic        bin1, v1, bo1, ov1;
  logic [7:0]  a8, b8, d8;
  logic        bin8, v8, bo8, ov8;
  logic [15:0] a16, b16, d16;
  logic        bin16, v16, bo16, ov16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .bin(bin1), .in_valid(v1),
    .diff(d1), .bout(bo1), .out_valid(ov1)
  );

  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .in_valid(v8),
    .diff(d8), .bout(bo8), .out_valid(ov8)
  );

  full_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .bin(bin16), .in_valid(v16),
    .diff(d16), .bout(bo16), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] ed, input logic eb, input logic ev);
    check({tag, ".diff"}, 64'(d8), 64'(ed));
    check({tag, ".bout"}, 64'(bo8), 64'(eb));
    check({tag, ".valid"}, 64'(ov8), 64'(ev));
  endtask

  logic [7:0] diff_tab, bout_tab;
  logic [2:0] idx;
  int          r;
  logic [15:0] exp_d16;
  logic        exp_b16, exp_v16;

  initial begin
    rst = 1'b1;
    a1 = '0; b1 = '0; bin1 = 1'b0; v1 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0; v8 = 1'b0;
    a16 = '0; b16 = '0; bin16 = 1'b0; v16 = 1'b0;

    // Reset state
    #2;
    check("rst.w1.valid", 64'(ov1), 64'd0);
    check("rst.w8.diff", 64'(d8), 64'd0);
    check("rst.w8.bout", 64'(bo8), 64'd0);
    check("rst.w16.valid", 64'(ov16), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check8("idle", 8'h00, 1'b0, 1'b0);

    // Exhaustive 1-bit truth table, back to back; index = {a, b, bin}
    diff_tab = 8'b1001_0110;
    bout_tab = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[2]; b1 = idx[1]; bin1 = idx[0]; v1 = 1'b1;
      tick();
      check($sformatf("w1[%0d].diff", i), 64'(d1), 64'(diff_tab[idx]));
      check($sformatf("w1[%0d].bout", i), 64'(bo1), 64'(bout_tab[idx]));
      check($sformatf("w1[%0d].valid", i), 64'(ov1), 64'd1);
    end
    v1 = 1'b0;

    // Directed 8-bit patterns including wrap and full borrow ripple
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; v8 = 1'b1; tick();
    check8("w8.5a-3c", 8'h1E, 1'b0, 1'b1);
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1; tick();
    check8("w8.0-0-1", 8'hFF, 1'b1, 1'b1);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; tick();
    check8("w8.80-01", 8'h7F, 1'b0, 1'b1);
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1; tick();
    check8("w8.01-02-1", 8'hFE, 1'b1, 1'b1);

    // Valid gating: results hold while in_valid is low
    v8 = 1'b0; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; tick();
    check8("w8.gate1", 8'hFE, 1'b1, 1'b0);
    a8 = 8'hC4; b8 = 8'h07; bin8 = 1'b1; tick();
    check8("w8.gate2", 8'hFE, 1'b1, 1'b0);

    // Asynchronous reset between edges discards the in-flight result
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; v8 = 1'b1; tick();
    check8("w8.prerst", 8'h1E, 1'b0, 1'b1);
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    #3 rst = 1'b1;
    #1;
    check8("w8.async", 8'h00, 1'b0, 1'b0);
    tick();
    check8("w8.inrst", 8'h00, 1'b0, 1'b0);
    #3 rst = 1'b0; v8 = 1'b0;
    tick();
    check8("w8.postrst", 8'h00, 1'b0, 1'b0);
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; v8 = 1'b1; tick();
    check8("w8.firstop", 8'hF0, 1'b1, 1'b1);
    v8 = 1'b0;

    // Random 16-bit against an integer model of a - b - bin
    exp_d16 = 16'h0000;
    exp_b16 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      bin16 = 1'($urandom_range(0, 1));
      v16 = ($urandom_range(0, 3) != 0);
      if (v16) begin
        r = int'(a16) - int'(b16) - int'(bin16);
        exp_b16 = (r < 0);
        exp_d16 = 16'((r + 131072) % 65536);
      end
      exp_v16 = v16;
      tick();
      check($sformatf("w16[%0d].diff", n), 64'(d16), 64'(exp_d16));
      check($sformatf("w16[%0d].bout", n), 64'(bo16), 64'(exp_b16));
      check($sformatf("w16[%0d].valid", n), 64'(ov16), 64'(exp_v16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
